// File: rtl/branch_resolve_queue.sv
// In-order fetch-prediction queue; compares predicted vs actual next PC at resolve, drives predictor/BTB update and fetch redirect.
// Latency: update/redirect outputs registered one cycle after the popping edge.
// Backpressure: push_ready = !full; mispredict or flush empties the queue and drops any same-cycle push.
module branch_resolve_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [DATA_WIDTH-1:0] push_pc,
    input  logic                  push_hit,
    input  logic                  push_pred,
    input  logic [DATA_WIDTH-1:0] push_target,
    input  logic                  res_valid,
    input  logic                  res_is_branch,
    input  logic                  res_is_jump,
    input  logic                  res_taken,
    input  logic [DATA_WIDTH-1:0] res_target,
    input  logic                  flush,
    output logic                  update_predictor,
    output logic                  update_btb,
    output logic                  actually_taken,
    output logic [DATA_WIDTH-1:0] resolved_pc,
    output logic [DATA_WIDTH-1:0] resolved_pc_target,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [PTR_W:0]        count,
    output logic                  underflow_err
);

    localparam int CW = PTR_W + 1;

    logic [DATA_WIDTH-1:0] pc_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] tgt_mem  [DEPTH];
    logic                  hit_mem  [DEPTH];
    logic                  pred_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]    count_q;

    logic                  full, empty;
    logic                  push_fire, pop;
    logic [DATA_WIDTH-1:0] rd_pc, rd_tgt, pc_plus4, pnpc, anpc;
    logic                  rd_hit, rd_pred, act_taken, mispredict, discard;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign push_ready = !full;
    assign count      = count_q;
    assign push_fire  = push_valid && push_ready;
    assign pop        = res_valid && !empty && !flush;

    assign rd_pc    = pc_mem[rd_ptr];
    assign rd_tgt   = tgt_mem[rd_ptr];
    assign rd_hit   = hit_mem[rd_ptr];
    assign rd_pred  = pred_mem[rd_ptr];
    assign pc_plus4 = rd_pc + DATA_WIDTH'(4);

    assign act_taken  = res_is_jump || (res_is_branch && res_taken);
    assign pnpc       = (rd_hit && rd_pred) ? rd_tgt : pc_plus4;
    assign anpc       = act_taken ? res_target : pc_plus4;
    assign mispredict = (pnpc != anpc);
    // Younger entries behind a mispredict are wrong-path, so they go too.
    assign discard    = flush || (pop && mispredict);

    always_ff @(posedge clk) begin
        if (push_fire) begin
            pc_mem[wr_ptr]   <= push_pc;
            tgt_mem[wr_ptr]  <= push_target;
            hit_mem[wr_ptr]  <= push_hit;
            pred_mem[wr_ptr] <= push_pred;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (discard) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)       rd_ptr <= rd_ptr + PTR_W'(1);
            count_q <= count_q + CW'(push_fire) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            update_predictor   <= 1'b0;
            update_btb         <= 1'b0;
            actually_taken     <= 1'b0;
            redirect_valid     <= 1'b0;
            resolved_pc        <= '0;
            resolved_pc_target <= '0;
            redirect_pc        <= '0;
            underflow_err      <= 1'b0;
        end else begin
            update_predictor <= pop && res_is_branch;
            actually_taken   <= pop && act_taken;
            update_btb       <= pop && act_taken && (!rd_hit || (rd_tgt != res_target));
            redirect_valid   <= pop && mispredict;
            if (pop) begin
                resolved_pc        <= rd_pc;
                resolved_pc_target <= res_target;
                redirect_pc        <= anpc;
            end
            if (res_valid && empty) underflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed scoreboard bench for branch_resolve_queue: a reference queue predicts each resolve's outputs.
module tb_branch_resolve_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid, push_ready, push_hit, push_pred;
    logic [31:0] push_pc, push_target;
    logic        res_valid, res_is_branch, res_is_jump, res_taken;
    logic [31:0] res_target;
    logic        flush;
    logic        update_predictor, update_btb, actually_taken, redirect_valid;
    logic [31:0] resolved_pc, resolved_pc_target, redirect_pc;
    logic [2:0]  count;
    logic        underflow_err;

    int compares = 0;
    int fails    = 0;

    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic        pred;
        logic [31:0] tgt;
    } rec_t;

    typedef struct {
        logic        upd_pred;
        logic        upd_btb;
        logic        taken;
        logic [31:0] rpc;
        logic [31:0] rtgt;
        logic        redir;
        logic [31:0] redir_pc;
    } exp_t;

    rec_t mq[$];
    exp_t eq[$];

    always #5 clk = ~clk;

    branch_resolve_queue #(.DATA_WIDTH(32), .DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
        .push_hit(push_hit), .push_pred(push_pred), .push_target(push_target),
        .res_valid(res_valid), .res_is_branch(res_is_branch), .res_is_jump(res_is_jump),
        .res_taken(res_taken), .res_target(res_target), .flush(flush),
        .update_predictor(update_predictor), .update_btb(update_btb),
        .actually_taken(actually_taken), .resolved_pc(resolved_pc),
        .resolved_pc_target(resolved_pc_target), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .count(count), .underflow_err(underflow_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compares++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic drive_idle();
        push_valid = 0; push_pc = 0; push_hit = 0; push_pred = 0; push_target = 0;
        res_valid = 0; res_is_branch = 0; res_is_jump = 0; res_taken = 0; res_target = 0;
        flush = 0;
    endtask

    // One clock: drive inputs, advance the reference model, then check registered outputs.
    task automatic cyc(input logic pv, input logic [31:0] ppc, input logic ph, input logic pp,
                       input logic [31:0] ptg, input logic rv, input logic rb, input logic rj,
                       input logic rt, input logic [31:0] rtg, input logic fl);
        rec_t  r, e;
        exp_t  x;
        logic  accept, drop, got;
        logic [31:0] pn, an;
        chk("push_ready", {31'b0, push_ready}, {31'b0, mq.size() < 4});
        accept = pv && (mq.size() < 4);
        drop = 0;
        got  = 0;
        if (fl) begin
            drop = 1;
        end else if (rv && mq.size() > 0) begin
            e = mq.pop_front();
            x.taken    = rj || (rb && rt);
            pn         = (e.hit && e.pred) ? e.tgt : e.pc + 32'd4;
            an         = x.taken ? rtg : e.pc + 32'd4;
            x.upd_pred = rb;
            x.upd_btb  = x.taken && (!e.hit || e.tgt != rtg);
            x.rpc      = e.pc;
            x.rtgt     = rtg;
            x.redir    = (pn != an);
            x.redir_pc = an;
            eq.push_back(x);
            got  = 1;
            drop = x.redir;
        end
        if (drop) mq.delete();
        else if (accept) begin
            r.pc = ppc; r.hit = ph; r.pred = pp; r.tgt = ptg;
            mq.push_back(r);
        end
        push_valid = pv; push_pc = ppc; push_hit = ph; push_pred = pp; push_target = ptg;
        res_valid = rv; res_is_branch = rb; res_is_jump = rj; res_taken = rt; res_target = rtg;
        flush = fl;
        @(posedge clk);
        #1;
        drive_idle();
        if (got) begin
            x = eq.pop_front();
            chk("update_predictor", {31'b0, update_predictor}, {31'b0, x.upd_pred});
            chk("update_btb", {31'b0, update_btb}, {31'b0, x.upd_btb});
            chk("actually_taken", {31'b0, actually_taken}, {31'b0, x.taken});
            chk("resolved_pc", resolved_pc, x.rpc);
            chk("resolved_pc_target", resolved_pc_target, x.rtgt);
            chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, x.redir});
            if (x.redir) chk("redirect_pc", redirect_pc, x.redir_pc);
        end else begin
            chk("no_update_predictor", {31'b0, update_predictor}, 32'd0);
            chk("no_update_btb", {31'b0, update_btb}, 32'd0);
            chk("no_redirect", {31'b0, redirect_valid}, 32'd0);
        end
        chk("count", {29'b0, count}, mq.size());
    endtask

    task automatic push(input logic [31:0] pc, input logic hit, input logic pred, input logic [31:0] tgt);
        cyc(1, pc, hit, pred, tgt, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic resolve(input logic br, input logic jp, input logic tk, input logic [31:0] tgt);
        cyc(0, 0, 0, 0, 0, 1, br, jp, tk, tgt, 0);
    endtask

    initial begin
        drive_idle();
        rst = 1;
        #1;
        chk("rst_count", {29'b0, count}, 32'd0);
        chk("rst_push_ready", {31'b0, push_ready}, 32'd1);
        chk("rst_underflow", {31'b0, underflow_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Reset mid-stream with three entries queued and stale outputs present
        push(32'h500, 0, 0, 0);
        push(32'h504, 0, 0, 0);
        push(32'h508, 0, 0, 0);
        push(32'h50C, 0, 0, 0);
        resolve(0, 0, 0, 0);
        chk("pre_rst_count", {29'b0, count}, 32'd3);
        rst = 1;
        #1;
        mq.delete();
        chk("mid_rst_count", {29'b0, count}, 32'd0);
        chk("mid_rst_push_ready", {31'b0, push_ready}, 32'd1);
        chk("mid_rst_resolved_pc", resolved_pc, 32'd0);
        chk("mid_rst_redirect_pc", redirect_pc, 32'd0);
        chk("mid_rst_flags", {28'b0, update_predictor, update_btb, actually_taken, redirect_valid}, 32'd0);
        @(posedge clk);
        #1 rst = 0;

        // Correctly predicted taken branch
        push(32'h100, 1, 1, 32'h200);
        resolve(1, 0, 1, 32'h200);

        // BTB miss on a taken jump
        push(32'h40, 0, 0, 0);
        resolve(0, 1, 0, 32'h80);
        chk("btb_miss_redirect_pc", redirect_pc, 32'h80);

        // Predicted-taken branch falls through: younger entries are discarded
        push(32'h10, 1, 1, 32'h30);
        push(32'h30, 0, 0, 0);
        push(32'h34, 0, 0, 0);
        cyc(1, 32'h38, 0, 0, 0, 1, 1, 0, 0, 32'h30, 0);
        chk("mispredict_redirect_pc", redirect_pc, 32'h14);
        chk("mispredict_count", {29'b0, count}, 32'd0);

        // Non-branch with a stale BTB hit+pred redirects to pc+4
        push(32'h900, 1, 1, 32'h2000);
        resolve(0, 0, 0, 32'h0);

        // Fill, attempt overflow, pop two, wrap the write pointer, drain in order
        push(32'hA00, 0, 0, 0);
        push(32'hA04, 0, 0, 0);
        push(32'hA08, 1, 0, 32'hB00);
        push(32'hA0C, 0, 0, 0);
        chk("full_push_ready", {31'b0, push_ready}, 32'd0);
        push(32'hDEAD, 0, 0, 0);
        cyc(1, 32'hBEEF, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        resolve(1, 0, 0, 32'h40);
        push(32'hA10, 0, 0, 0);
        cyc(1, 32'hA14, 0, 0, 0, 1, 1, 0, 0, 32'h80, 0);
        resolve(0, 0, 0, 0);
        resolve(0, 0, 0, 0);
        resolve(1, 1, 0, 32'hA18);
        chk("drain_count", {29'b0, count}, 32'd0);

        // Resolve on an empty queue, then flush against a push and a resolve
        resolve(0, 1, 0, 32'h1234);
        chk("underflow_set", {31'b0, underflow_err}, 32'd1);
        push(32'hC00, 0, 0, 0);
        push(32'hC04, 0, 0, 0);
        cyc(1, 32'hC08, 0, 0, 0, 1, 0, 1, 0, 32'hF00, 1);
        chk("flush_count", {29'b0, count}, 32'd0);
        push(32'hD00, 1, 1, 32'hD40);
        resolve(1, 0, 1, 32'hD40);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("underflow_sticky", {31'b0, underflow_err}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
